keyboard_rx_ctrl: RTL and testbench
===================================

KEYBOARD_RX_CTRL -- requirements
Module: keyboard_rx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, max clk cycles allowed between PS/2 falling edges inside a frame.
REQ-002 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock from the keyboard.
REQ-005 SHALL have port ps2_data  input  1  asynchronous PS/2 data from the keyboard.
REQ-006 SHALL have port keyb_char  output  32  last four good scan codes, newest in [7:0], oldest in [31:24]; feeds display8digit directly.
REQ-007 SHALL have port code_valid  output  1  one-cycle pulse when a new byte enters keyb_char.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse when a frame is dropped for bad parity.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a frame is dropped for bad stop bit or timeout.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; ps2_clk_s and ps2_data_s are the second-stage outputs.
REQ-011 SHALL register ps2_clk_s into ps2_clk_d; fall = ps2_clk_d & ~ps2_clk_s; all bit sampling uses ps2_data_s in a cycle where fall=1.
REQ-012 SHALL implement the FSM states IDLE, DATA, PARITY and STOP.
REQ-013 In IDLE on fall, SHALL go to DATA if ps2_data_s=0 (start bit); otherwise SHALL stay in IDLE with no error pulse.
REQ-014 In DATA, SHALL shift ps2_data_s into an 8-bit shift register LSB-first on each fall; after the 8th bit SHALL go to PARITY.
REQ-015 In PARITY on fall, SHALL capture the parity bit and go to STOP.
REQ-016 In STOP on fall, SHALL go to IDLE and resolve the frame by the first matching rule below:
- stop bit = 0: frame_err.
- odd parity fails (XOR of 8 data bits and parity bit = 0): parity_err.
- otherwise: accept.
REQ-017 On accept, keyb_char SHALL become {keyb_char[23:0], byte} and code_valid SHALL be 1, both in the cycle after the stop-bit fall cycle.
REQ-018 parity_err and frame_err SHALL be 1 in the cycle after the triggering fall cycle, for exactly one cycle; keyb_char SHALL NOT change on error.
REQ-019 At most one of code_valid, parity_err and frame_err SHALL be 1 in any cycle.
REQ-020 The timeout counter SHALL clear on every fall and in IDLE, and SHALL increment each cycle in DATA, PARITY or STOP without fall.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES-1 without fall, the FSM SHALL go to IDLE, discard the partial byte and pulse frame_err the next cycle.
REQ-022 If fall and the timeout terminal count occur in the same cycle, fall SHALL take priority and the counter SHALL clear.
REQ-023 The timeout counter SHALL be sized to $clog2(TIMEOUT_CYCLES)+1 bits and SHALL never wrap.
REQ-024 Consecutive valid frames SHALL each produce one code_valid; code_valid SHALL NOT fire twice for one frame.
REQ-025 A start bit arriving in the same cycle the FSM returns to IDLE is not possible (fall spacing ≥ 1 PS/2 bit period), and the design SHALL make no provision for it.

Reset
REQ-026 While reset=1 at a rising clk edge, the block SHALL:
- set the FSM to IDLE;
- set keyb_char to 32'h00000000;
- clear code_valid, parity_err, frame_err, the shift register and the timeout counter;
- set the synchronizer and ps2_clk_d flops to 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no error pulse.
REQ-028 After reset deasserts, the next start bit SHALL begin a fresh frame.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> one code_valid; keyb_char=32'h0000001C.
- Frames 0x1C, 0xF0, 0x1C, 0x32 -> keyb_char=32'h1CF01C32; exactly four code_valid pulses.
- Frame 0x1C with parity bit 1 -> one parity_err pulse; keyb_char unchanged; no code_valid.
- Frame 0x1C with stop bit 0 -> one frame_err pulse; keyb_char unchanged.
- TIMEOUT_CYCLES=50 and ps2_clk held high after 4 data bits -> frame_err exactly 51 cycles after the 4th fall; a following good 0x45 frame gives keyb_char[7:0]=8'h45.
- Reset after 5 data bits -> no error pulse; keyb_char=0; a following good 0x29 frame gives keyb_char=32'h00000029.

Source files
------------

// File: rtl/keyboard_rx_ctrl.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames and keeps
// the last four good scan codes for the display.
module keyboard_rx_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyb_char,
  output logic        code_valid,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic ps2_clk_m, ps2_clk_s, ps2_clk_d;
  logic ps2_data_m, ps2_data_s;
  logic fall;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            par_q, par_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic [31:0]     char_q, char_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  assign fall = ps2_clk_d & ~ps2_clk_s;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    char_d    = char_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    // A PS/2 edge always wins over the terminal count, so the counter cannot wrap.
    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TermCnt) begin
      tmo_d   = '0;
      state_d = StIdle;
      shift_d = '0;
      ferr_d  = 1'b1;
    end else begin
      tmo_d = tmo_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (fall && !ps2_data_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = ps2_data_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (!ps2_data_s) begin
            ferr_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
          end else begin
            char_d  = {char_q[23:0], shift_q};
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_m  <= 1'b1;
      ps2_clk_s  <= 1'b1;
      ps2_clk_d  <= 1'b1;
      ps2_data_m <= 1'b1;
      ps2_data_s <= 1'b1;
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      char_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      ps2_clk_m  <= ps2_clk;
      ps2_clk_s  <= ps2_clk_m;
      ps2_clk_d  <= ps2_clk_s;
      ps2_data_m <= ps2_data;
      ps2_data_s <= ps2_data_m;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      char_q     <= char_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign keyb_char  = char_q;
  assign code_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_keyboard_rx_ctrl.sv
// Self-checking bench for keyboard_rx_ctrl: directed frames plus randomized frames checked
// against a scan-code history model.
module tb_keyboard_rx_ctrl;

  localparam int unsigned Tmo = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyb_char;
  logic        code_valid, parity_err, frame_err;

  int checks = 0, errors = 0;
  int cyc = 0;
  int cv_cnt = 0, pe_cnt = 0, fe_cnt = 0, ovl_cnt = 0;
  int cv_last = 0, pe_last = 0, fe_last = 0;
  int last_fall = 0, stop_cyc = 0;
  logic [31:0] exp_char = '0;

  keyboard_rx_ctrl #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keyb_char  (keyb_char),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles and remembers the cycle each output was last high.
  always @(negedge clk) begin
    if (code_valid === 1'b1) begin cv_cnt++; cv_last = cyc; end
    if (parity_err === 1'b1) begin pe_cnt++; pe_last = cyc; end
    if (frame_err === 1'b1) begin fe_cnt++; fe_last = cyc; end
    if (int'(code_valid === 1'b1) + int'(parity_err === 1'b1) + int'(frame_err === 1'b1) > 1)
      ovl_cnt++;
  end

  task automatic send_bit(input logic v, input int half);
    @(negedge clk);
    ps2_data = v;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int half);
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit((~^b) ^ par_bad, half);
    send_bit(~stop_bad, half);
    stop_cyc = last_fall;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (keyb_char !== 32'h0) begin errors++; $display("FAIL rst_char: got %h want 0", keyb_char); end
    if (code_valid !== 1'b0) begin errors++; $display("FAIL rst_cv: got %b want 0", code_valid); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_pe: got %b want 0", parity_err); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_fe: got %b want 0", frame_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int cv0 = cv_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 4);
    exp_char = {exp_char[23:0], 8'h1C};
    checks += 3;
    if (cv_cnt - cv0 != 1) begin errors++; $display("FAIL single_cv: got %0d want 1", cv_cnt - cv0); end
    if (keyb_char !== 32'h0000001C) begin
      errors++; $display("FAIL single_char: got %h want 0000001c", keyb_char);
    end
    if (cv_last != stop_cyc + 3) begin
      errors++; $display("FAIL single_lat: got %0d want %0d", cv_last, stop_cyc + 3);
    end
  endtask

  task automatic test_four_frames();
    int cv0 = cv_cnt;
    int ov0 = ovl_cnt;
    logic [7:0] seq [4] = '{8'h1C, 8'hF0, 8'h1C, 8'h32};
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b0, 1'b0, 5);
      exp_char = {exp_char[23:0], seq[i]};
    end
    checks += 3;
    if (cv_cnt - cv0 != 4) begin errors++; $display("FAIL four_cv: got %0d want 4", cv_cnt - cv0); end
    if (keyb_char !== 32'h1CF01C32) begin
      errors++; $display("FAIL four_char: got %h want 1cf01c32", keyb_char);
    end
    if (ovl_cnt != ov0) begin errors++; $display("FAIL four_ovl: got %0d want 0", ovl_cnt - ov0); end
  endtask

  task automatic test_parity_err();
    int cv0 = cv_cnt;
    int pe0 = pe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 4);
    checks += 4;
    if (pe_cnt - pe0 != 1) begin errors++; $display("FAIL par_pe: got %0d want 1", pe_cnt - pe0); end
    if (pe_last != stop_cyc + 3) begin
      errors++; $display("FAIL par_lat: got %0d want %0d", pe_last, stop_cyc + 3);
    end
    if (cv_cnt != cv0) begin errors++; $display("FAIL par_cv: got %0d want 0", cv_cnt - cv0); end
    if (keyb_char !== exp_char) begin
      errors++; $display("FAIL par_char: got %h want %h", keyb_char, exp_char);
    end
  endtask

  task automatic test_stop_err();
    int cv0 = cv_cnt;
    int pe0 = pe_cnt;
    int fe0 = fe_cnt;
    // Bad parity too: the stop-bit error must win.
    send_frame(8'h1C, 1'b1, 1'b1, 4);
    checks += 4;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL stop_fe: got %0d want 1", fe_cnt - fe0); end
    if (fe_last != stop_cyc + 3) begin
      errors++; $display("FAIL stop_lat: got %0d want %0d", fe_last, stop_cyc + 3);
    end
    if (pe_cnt + cv_cnt != pe0 + cv0) begin
      errors++; $display("FAIL stop_other: got %0d want 0", pe_cnt + cv_cnt - pe0 - cv0);
    end
    if (keyb_char !== exp_char) begin
      errors++; $display("FAIL stop_char: got %h want %h", keyb_char, exp_char);
    end
  endtask

  task automatic test_timeout();
    int cv0 = cv_cnt;
    int fe0 = fe_cnt;
    int f4;
    logic [7:0] b = 8'hA6;
    send_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) send_bit(b[i], 4);
    f4 = last_fall;
    repeat (70) @(negedge clk);
    checks += 3;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL tmo_fe: got %0d want 1", fe_cnt - fe0); end
    // Fall is seen two clocks after the drive; the error lands 51 cycles after that.
    if (fe_last != f4 + 53) begin
      errors++; $display("FAIL tmo_lat: got %0d want %0d", fe_last, f4 + 53);
    end
    if (cv_cnt != cv0) begin errors++; $display("FAIL tmo_cv: got %0d want 0", cv_cnt - cv0); end
    send_frame(8'h45, 1'b0, 1'b0, 4);
    exp_char = {exp_char[23:0], 8'h45};
    checks += 2;
    if (keyb_char[7:0] !== 8'h45) begin
      errors++; $display("FAIL tmo_next: got %h want 45", keyb_char[7:0]);
    end
    if (keyb_char !== exp_char) begin
      errors++; $display("FAIL tmo_char: got %h want %h", keyb_char, exp_char);
    end
  endtask

  task automatic test_mid_frame_reset();
    int ev0 = cv_cnt + pe_cnt + fe_cnt;
    logic [7:0] b = 8'h5B;
    send_bit(1'b0, 4);
    for (int i = 0; i < 5; i++) send_bit(b[i], 4);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    exp_char = '0;
    checks += 2;
    if (cv_cnt + pe_cnt + fe_cnt != ev0) begin
      errors++; $display("FAIL mrst_pulse: got %0d want 0", cv_cnt + pe_cnt + fe_cnt - ev0);
    end
    if (keyb_char !== 32'h0) begin errors++; $display("FAIL mrst_char: got %h want 0", keyb_char); end
    send_frame(8'h29, 1'b0, 1'b0, 4);
    exp_char = {exp_char[23:0], 8'h29};
    checks++;
    if (keyb_char !== 32'h00000029) begin
      errors++; $display("FAIL mrst_next: got %h want 00000029", keyb_char);
    end
  endtask

  task automatic test_back_to_back();
    int cv0 = cv_cnt;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b = 8'($urandom);
      send_frame(b, 1'b0, 1'b0, 3);
      exp_char = {exp_char[23:0], b};
      checks++;
      if (cv_last != stop_cyc + 3) begin
        errors++; $display("FAIL b2b_lat: got %0d want %0d", cv_last, stop_cyc + 3);
      end
    end
    checks += 2;
    if (cv_cnt - cv0 != 6) begin errors++; $display("FAIL b2b_cv: got %0d want 6", cv_cnt - cv0); end
    if (keyb_char !== exp_char) begin
      errors++; $display("FAIL b2b_char: got %h want %h", keyb_char, exp_char);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int cv0 = cv_cnt, pe0 = pe_cnt, fe0 = fe_cnt, ov0 = ovl_cnt;
      logic [7:0] b = 8'($urandom);
      int kind = int'($urandom_range(9, 0));
      bit par_bad = (kind == 7 || kind == 9);
      bit stop_bad = (kind == 8 || kind == 9);
      int half = int'($urandom_range(20, 3));
      int want_cv = (!stop_bad && !par_bad) ? 1 : 0;
      int want_pe = (!stop_bad && par_bad) ? 1 : 0;
      int want_fe = stop_bad ? 1 : 0;
      send_frame(b, par_bad, stop_bad, half);
      if (want_cv == 1) exp_char = {exp_char[23:0], b};
      checks += 5;
      if (cv_cnt - cv0 != want_cv) begin
        errors++; $display("FAIL rnd_cv: got %0d want %0d", cv_cnt - cv0, want_cv);
      end
      if (pe_cnt - pe0 != want_pe) begin
        errors++; $display("FAIL rnd_pe: got %0d want %0d", pe_cnt - pe0, want_pe);
      end
      if (fe_cnt - fe0 != want_fe) begin
        errors++; $display("FAIL rnd_fe: got %0d want %0d", fe_cnt - fe0, want_fe);
      end
      if (ovl_cnt != ov0) begin errors++; $display("FAIL rnd_ovl: got %0d want 0", ovl_cnt - ov0); end
      if (keyb_char !== exp_char) begin
        errors++; $display("FAIL rnd_char: got %h want %h", keyb_char, exp_char);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_four_frames();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_mid_frame_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
